mux_rr_arbiter: RTL

- Two-requester round-robin arbiter that shares one 2:1 Multiplexor datapath.
- Drives the mux select from the current grant and registers the selected word into a one-entry output stage with a valid/ready handshake.
- Sits in front of any shared DATA_WIDTH-bit resource that two producers feed.

---
 rtl/mux_rr_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - two-requester round-robin arbiter feeding a registered 2:1 mux output stage
// Optional request locking is compiled in when MUX_RR_ARBITER_LOCK_EN is defined.
module mux_rr_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in0_valid,
    input  logic [0:DATA_WIDTH-1] in0_data,
    output logic                  in0_ready,
    input  logic                  in1_valid,
    input  logic [0:DATA_WIDTH-1] in1_data,
    output logic                  in1_ready,
`ifdef MUX_RR_ARBITER_LOCK_EN
    input  logic                  in0_lock,
    input  logic                  in1_lock,
    output logic                  lock_owner_active,
`endif
    output logic                  sel,
    output logic                  out_valid,
    output logic [0:DATA_WIDTH-1] out_data,
    output logic                  out_src,
    input  logic                  out_ready
);

    logic                  out_valid_q, out_valid_d;
    logic [0:DATA_WIDTH-1] out_data_q, out_data_d;
    logic                  out_src_q, out_src_d;
    logic                  last_grant_q, last_grant_d;
    logic                  grant;
    logic                  space;
    logic                  xfer;
`ifdef MUX_RR_ARBITER_LOCK_EN
    logic                  lock_q, lock_d;
`endif

    always_comb begin
        grant = ~last_grant_q;
        if (in0_valid && !in1_valid) begin
            grant = 1'b0;
        end else if (in1_valid && !in0_valid) begin
            grant = 1'b1;
        end
`ifdef MUX_RR_ARBITER_LOCK_EN
        // The lock owner is always the last granted requester, so last_grant names it.
        if (lock_q) begin
            grant = last_grant_q;
        end
`endif
    end

    // Readies are gated by rst_n so no handshake can complete while reset is held.
    assign space     = ~out_valid_q | out_ready;
    assign in0_ready = rst_n & space & ~grant & in0_valid;
    assign in1_ready = rst_n & space & grant & in1_valid;
    assign xfer      = in0_ready | in1_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;
        if (xfer) begin
            out_valid_d  = 1'b1;
            out_data_d   = grant ? in1_data : in0_data;
            out_src_d    = grant;
            last_grant_d = grant;
        end else if (out_valid_q && out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

`ifdef MUX_RR_ARBITER_LOCK_EN
    always_comb begin
        lock_d = lock_q;
        if (xfer) begin
            lock_d = grant ? in1_lock : in0_lock;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end

    assign lock_owner_active = lock_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign sel       = grant;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule
